uart_poll_master: RTL
=====================

// Module: uart_poll_master
// PURPOSE
//  WISHBONE initiator that drives the MiniUART register slave from the other end of the bus.
//  Converts a byte-stream interface (tx valid/ready in, rx valid/ready out) into polled register accesses:
//   - optional post-reset divisor programming;
//   - LSR polling;
//   - DATA reads with a receive-consume write;
//   - DATA writes.
//  Sits between a byte producer/consumer (console, loader FSM) and the UART slave.
// PARAMETERS
//  PROG_DIV   1        1: write DIVR then DIVT after reset; 0: skip, keep slave defaults
//  DIVR_INIT  16'd0    value written to DIVR when PROG_DIV=1 (top sets baud constant)
//  DIVT_INIT  16'd0    value written to DIVT when PROG_DIV=1
//  TX_GUARD   4        idle cycles after a DATA write before next LSR poll (lets ts fall)
//  POLL_GAP   0        idle cycles between consecutive LSR polls (bus load throttle)
// PORTS
//  CLK_I      in   1   clock
//  RST_I      in   1   reset, synchronous, active-low
//  ADD_O      out  3   bus address [4:2], register offset
//  DAT_O      out  32  bus write data
//  DAT_I      in   32  bus read data
//  STB_O      out  1   strobe; held until ACK_I
//  WE_O       out  1   write enable
//  ACK_I      in   1   acknowledge (slave may return it combinationally)
//  tx_byte    in   8   byte to send
//  tx_valid   in   1   tx_byte valid
//  tx_ready   out  1   byte accepted this cycle (valid&ready handshake)
//  rx_byte    out  8   received byte
//  rx_valid   out  1   rx_byte valid; held until rx_ready
//  rx_ready   in   1   consumer accepts rx_byte
//  init_done  out  1   divisor programming finished; stays 1 until reset
// BEHAVIOUR
//  Reset (RST_I=0 at posedge): all outputs 0; state -> INIT_DIVR (PROG_DIV=1) or POLL (PROG_DIV=0).
//  Bus access: ADD_O/DAT_O/WE_O/STB_O are registered and stable while STB_O=1.
//   - Access completes on the first posedge with ACK_I=1; STB_O drops the next cycle.
//   - One-cycle ACK gives two cycles per access.
//   - Read data is sampled at the completing edge.
//  States and transitions:
//   - INIT_DIVR: write {16'b0,DIVR_INIT} to OFF_UART_DIVR, then INIT_DIVT.
//   - INIT_DIVT: write DIVT_INIT to OFF_UART_DIVT; init_done<=1; then POLL.
//   - POLL: read OFF_UART_LSR; latch rs=DAT_I[0], ts=DAT_I[5]; then EVAL.
//   - EVAL, single cycle, priority order:
//     a) rs=1 and !rx_valid: go RX_READ.
//     b) rs=1 and rx_valid: go GAP. TX is blocked, because any write clears rs and would lose the byte.
//     c) rs=0, ts=1, tx_valid: tx_ready=1 this cycle, latch tx_byte, go TX_WRITE.
//     d) otherwise: go GAP.
//   - RX_READ: read OFF_UART_DATA; rx_byte<=DAT_I[7:0], rx_valid<=1; then RX_ACK.
//   - RX_ACK: write 32'b0 to OFF_UART_LSR. This is the consume write: it clears rs and changes no slave register. Then GAP.
//   - TX_WRITE: write {24'b0,byte} to OFF_UART_DATA; then GUARD.
//   - GUARD: count TX_GUARD cycles, then POLL.
//   - GAP: count POLL_GAP cycles (0 means straight through), then POLL.
//  rx_valid clears on the cycle rx_valid&rx_ready; it is independent of bus state.
//   - rx_byte holds its value while rx_valid=1.
//  tx_ready is high only in EVAL case c; never asserted before init_done.
//  Two writes are never back-to-back: at least one non-write cycle precedes each DATA write, which the slave's load toggle requires.
//  Simultaneous: rs=1 and tx_valid=1 -> RX served first; TX waits for a later poll.
//  Known race: a byte arriving between LSR sample and TX_WRITE is cleared by that write. Limit: a single RX overrun; accepted.
//  Reset mid-access: STB_O drops the next cycle; any latched tx byte is discarded without being sent.
//  Counters are sized $clog2(max(TX_GUARD,POLL_GAP)+1) bits and saturate safely at 0.
// STRUCTURE
//  Shared header head_uart.v holds constants; this block adds nothing else to it:
//   - OFF_UART_DATA/LSR/DIVR/DIVT;
//   - `LSR_RS_BIT (0) and `LSR_TS_BIT (5);
//   - BAUD_* constants.
//  Sub-module uart_wb_access: one WISHBONE access engine.
//   - Inputs: start, we, addr, wdata.
//   - Outputs: STB_O/WE_O/ADD_O/DAT_O, done pulse, rdata.
//   - The FSM in uart_poll_master sequences it.
// TESTING (bench: MiniUART slave model + serial loopback RxD=TxD, or a BFM slave)
//  1 Reset, PROG_DIV=1, DIVR_INIT=16'h0145, DIVT_INIT=16'h028B -> writes DIVR=0x145, then DIVT=0x28B, then init_done=1, then LSR reads begin.
//  2 BFM LSR=0x20, tx_valid with tx_byte=8'hA5 -> tx_ready 1 cycle; DATA write DAT_O=0x000000A5; no LSR read for TX_GUARD=4 cycles.
//  3 BFM LSR=0x01, DATA=0x3C, rx_ready=1 -> read DATA; rx_byte=0x3C, rx_valid=1; next access is write to LSR offset with DAT_O=0.
//  4 LSR=0x21 with tx_valid=1 -> RX read and consume write first; tx_ready stays 0 until a later poll sees rs=0.
//  5 rx_ready=0 holding byte 0x11, LSR=0x21, tx_valid=1 -> no DATA read, no write, tx_ready=0; rx_byte stays 0x11.
//  6 RST_I low during STB_O=1 of TX_WRITE -> all outputs 0 next cycle; after release the byte is not written; loopback 0x55 round-trips end to end.

Source files
------------

// File: rtl/uart_poll_master_pkg.sv
// Shared constants and types for the MiniUART polling master.
//  - Register offsets as seen on ADD_O (address bits [4:2]).
//  - LSR status bit positions: receive-ready (rs) and transmit-ready (ts).
//  - Common baud constants plus a divisor helper for the instantiating top.
//  - Master FSM state type and the idle-counter width helper.
package uart_poll_master_pkg;

    localparam logic [2:0] OFF_UART_DATA = 3'd0;
    localparam logic [2:0] OFF_UART_LSR  = 3'd1;
    localparam logic [2:0] OFF_UART_DIVR = 3'd2;
    localparam logic [2:0] OFF_UART_DIVT = 3'd3;

    localparam int unsigned LSR_RS_BIT = 0;
    localparam int unsigned LSR_TS_BIT = 5;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    typedef enum logic [3:0] {
        StInitDivr,
        StInitDivt,
        StPoll,
        StEval,
        StRxRead,
        StRxAck,
        StTxWrite,
        StGuard,
        StGap
    } state_e;

    // Divisor for a 16x oversampling UART.
    function automatic logic [15:0] baud_div(input int unsigned clk_hz, input int unsigned baud);
        return 16'(clk_hz / (16 * baud));
    endfunction

    // Width of a down-counter able to hold max(a, b); never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_poll_master_wb_access.sv
// Single WISHBONE access engine.
//  Launches one access when start is seen while idle, holds the registered bus outputs stable
//  until ACK_I, then drops STB_O on the following cycle.
//  Ports:
//   CLK_I, RST_I          clock, synchronous active-low reset
//   start, we, addr, wdata access request (sampled only while idle)
//   STB_O, WE_O, ADD_O, DAT_O  registered bus outputs
//   ACK_I, DAT_I          bus acknowledge and read data
//   done                  high in the cycle the access completes (STB_O & ACK_I)
//   rdata                 read data, valid while done is high
module uart_wb_access
    import uart_poll_master_pkg::*;
(
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic        STB_O,
    output logic        WE_O,
    output logic [2:0]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I,
    output logic        done,
    output logic [31:0] rdata
);

    // Completion is combinational so the sequencer samples read data on the completing edge
    // and can launch the next access one cycle later.
    assign done  = STB_O & ACK_I;
    assign rdata = DAT_I;

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            STB_O <= 1'b0;
            WE_O  <= 1'b0;
            ADD_O <= 3'd0;
            DAT_O <= 32'd0;
        end else if (STB_O) begin
            if (ACK_I) begin
                STB_O <= 1'b0;
                WE_O  <= 1'b0;
            end
        end else if (start) begin
            STB_O <= 1'b1;
            WE_O  <= we;
            ADD_O <= addr;
            DAT_O <= wdata;
        end
    end

endmodule

// File: rtl/uart_poll_master.sv
// WISHBONE initiator driving the MiniUART register slave from a byte-stream interface.
//  Optionally programs DIVR/DIVT after reset, then polls LSR forever: received bytes are read
//  from DATA and released with a consume write to LSR; bytes to send are written to DATA when
//  the transmitter is ready and no received byte is pending.
//  Ports:
//   CLK_I, RST_I                 clock, synchronous active-low reset
//   ADD_O/DAT_O/STB_O/WE_O       registered bus outputs; ACK_I/DAT_I bus inputs
//   tx_byte/tx_valid/tx_ready    byte to send, valid/ready handshake
//   rx_byte/rx_valid/rx_ready    received byte, held until accepted
//   init_done                    divisor programming finished
module uart_poll_master
    import uart_poll_master_pkg::*;
#(
    parameter bit          PROG_DIV  = 1'b1,
    parameter logic [15:0] DIVR_INIT = 16'd0,
    parameter logic [15:0] DIVT_INIT = 16'd0,
    parameter int unsigned TX_GUARD  = 4,
    parameter int unsigned POLL_GAP  = 0
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic [2:0]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done
);

    localparam int unsigned   CntW      = cnt_width(TX_GUARD, POLL_GAP);
    localparam logic [CntW-1:0] GuardLoad = CntW'(TX_GUARD);
    localparam logic [CntW-1:0] GapLoad   = CntW'(POLL_GAP);

    state_e           state_q;
    logic             rs_q;
    logic             ts_q;
    logic [7:0]       tx_hold_q;
    logic [CntW-1:0]  cnt_q;

    logic             acc_start;
    logic             acc_we;
    logic [2:0]       acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_done;
    logic [31:0]      acc_rdata;
    logic             unused_rdata;

    assign unused_rdata = ^acc_rdata[31:8];

    // Access request per state; the engine ignores start while its strobe is up.
    always_comb begin
        acc_start = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = OFF_UART_LSR;
        acc_wdata = 32'd0;
        unique case (state_q)
            StInitDivr: begin
                acc_start = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = OFF_UART_DIVR;
                acc_wdata = {16'd0, DIVR_INIT};
            end
            StInitDivt: begin
                acc_start = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = OFF_UART_DIVT;
                acc_wdata = {16'd0, DIVT_INIT};
            end
            StPoll: begin
                acc_start = 1'b1;
                acc_addr  = OFF_UART_LSR;
            end
            StRxRead: begin
                acc_start = 1'b1;
                acc_addr  = OFF_UART_DATA;
            end
            StRxAck: begin
                // Consume write: clears rs in the slave without touching any register.
                acc_start = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = OFF_UART_LSR;
            end
            StTxWrite: begin
                acc_start = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = OFF_UART_DATA;
                acc_wdata = {24'd0, tx_hold_q};
            end
            default: ;
        endcase
    end

    // Send only when nothing was received: any write would clear rs and lose the byte.
    assign tx_ready = (state_q == StEval) && !rs_q && ts_q && tx_valid && init_done;

    uart_wb_access u_access (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .start (acc_start),
        .we    (acc_we),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .STB_O (STB_O),
        .WE_O  (WE_O),
        .ADD_O (ADD_O),
        .DAT_O (DAT_O),
        .ACK_I (ACK_I),
        .DAT_I (DAT_I),
        .done  (acc_done),
        .rdata (acc_rdata)
    );

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q   <= PROG_DIV ? StInitDivr : StPoll;
            rs_q      <= 1'b0;
            ts_q      <= 1'b0;
            tx_hold_q <= 8'd0;
            cnt_q     <= '0;
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            if (!PROG_DIV) begin
                init_done <= 1'b1;
            end
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            unique case (state_q)
                StInitDivr: begin
                    if (acc_done) state_q <= StInitDivt;
                end
                StInitDivt: begin
                    if (acc_done) begin
                        init_done <= 1'b1;
                        state_q   <= StPoll;
                    end
                end
                StPoll: begin
                    if (acc_done) begin
                        rs_q    <= acc_rdata[LSR_RS_BIT];
                        ts_q    <= acc_rdata[LSR_TS_BIT];
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    if (rs_q && !rx_valid) begin
                        state_q <= StRxRead;
                    end else if (tx_ready) begin
                        tx_hold_q <= tx_byte;
                        state_q   <= StTxWrite;
                    end else if (POLL_GAP == 0) begin
                        state_q <= StPoll;
                    end else begin
                        cnt_q   <= GapLoad;
                        state_q <= StGap;
                    end
                end
                StRxRead: begin
                    if (acc_done) begin
                        rx_byte  <= acc_rdata[7:0];
                        rx_valid <= 1'b1;
                        state_q  <= StRxAck;
                    end
                end
                StRxAck: begin
                    if (acc_done) begin
                        if (POLL_GAP == 0) begin
                            state_q <= StPoll;
                        end else begin
                            cnt_q   <= GapLoad;
                            state_q <= StGap;
                        end
                    end
                end
                StTxWrite: begin
                    if (acc_done) begin
                        if (TX_GUARD == 0) begin
                            state_q <= StPoll;
                        end else begin
                            cnt_q   <= GuardLoad;
                            state_q <= StGuard;
                        end
                    end
                end
                StGuard, StGap: begin
                    // Loaded with N, leaves after N cycles; <=1 also covers a stray zero.
                    if (cnt_q <= CntW'(1)) begin
                        state_q <= StPoll;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StPoll;
            endcase
        end
    end

endmodule
